// File: rtl/regfile_writeback_if.sv
// ----------------------------------------------------------------------------
// regfile_writeback_if
// Bundles every non-clock signal of the register-file write-back block.
//   alu_*  : ALU result handshake (valid/ready, destination, data)
//   mem_*  : load result handshake (valid/ready, destination, data)
//   write, rd_addr, data_in : registered register-file write port
//   q_rs_addr/q_rt_addr -> fwd_*_hit/fwd_*_data : forwarding lookups
//   count  : current queue occupancy
// Modports: slave = the write-back block, master = whoever drives it.
// ----------------------------------------------------------------------------
interface regfile_writeback_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic              write;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] data_in;

    logic [ADDR_W-1:0] q_rs_addr;
    logic [ADDR_W-1:0] q_rt_addr;
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic [DATA_W-1:0] fwd_rs_data;
    logic [DATA_W-1:0] fwd_rt_data;

    logic [CNT_W-1:0]  count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  q_rs_addr, q_rt_addr,
        output alu_ready, mem_ready,
        output write, rd_addr, data_in,
        output fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
        output count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output q_rs_addr, q_rt_addr,
        input  alu_ready, mem_ready,
        input  write, rd_addr, data_in,
        input  fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
        input  count
    );
endinterface

// File: rtl/regfile_writeback.sv
// ----------------------------------------------------------------------------
// regfile_writeback
// Collects ALU and load results into an ordered queue and drains one entry
// per cycle onto the register-file write port. Two forwarding lookups return
// the youngest in-flight value for a register.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : regfile_writeback_if.slave (handshakes, write port, lookups, count)
// ----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    regfile_writeback_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage is kept in flops: forwarding must look at every entry.
    logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
    logic [ADDR_W-1:0] ent_rd_d   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              write_q, write_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;

    logic [CNT_W-1:0]  free_slots;
    logic              alu_ready_w, mem_ready_w;
    logic              alu_push, mem_push, pop;

    // Ready depends only on the pre-edge occupancy; a pop in the same cycle
    // is not credited, so ready is never speculative.
    assign free_slots  = CNT_W'(DEPTH) - count_q;
    assign alu_ready_w = (free_slots >= CNT_W'(1));
    assign mem_ready_w = bus.alu_valid ? (free_slots >= CNT_W'(2))
                                       : (free_slots >= CNT_W'(1));
    assign alu_push    = bus.alu_valid & alu_ready_w;
    assign mem_push    = bus.mem_valid & mem_ready_w;
    assign pop         = (count_q != '0);

    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        // ALU entry takes the tail slot first so it is older than the load.
        if (alu_push) begin
            ent_rd_d[tail_q]   = bus.alu_rd;
            ent_data_d[tail_q] = bus.alu_data;
        end
        if (mem_push) begin
            ent_rd_d[tail_q + PTR_W'(alu_push)]   = bus.mem_rd;
            ent_data_d[tail_q + PTR_W'(alu_push)] = bus.mem_data;
        end
        tail_d  = tail_q + PTR_W'(alu_push) + PTR_W'(mem_push);
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);

        // Output register holds its last address/data when idle.
        write_d   = pop;
        rd_addr_d = rd_addr_q;
        data_in_d = data_in_q;
        if (pop) begin
            rd_addr_d = ent_rd_q[head_q];
            data_in_d = ent_data_q[head_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            write_q   <= 1'b0;
            rd_addr_q <= '0;
            data_in_q <= '0;
        end else begin
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            write_q    <= write_d;
            rd_addr_q  <= rd_addr_d;
            data_in_q  <= data_in_d;
        end
    end

    // Entries listed by age: slot_idx[0] is the oldest queued entry.
    logic [PTR_W-1:0] slot_idx   [DEPTH];
    logic             slot_valid [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign slot_idx[gi]   = head_q + PTR_W'(gi);
            assign slot_valid[gi] = (CNT_W'(gi) < count_q);
        end
    endgenerate

    logic              rs_hit, rt_hit;
    logic [DATA_W-1:0] rs_data, rt_data;

    // Scan oldest to youngest so later matches overwrite earlier ones; the
    // output register is older than anything still queued.
    always_comb begin
        rs_hit  = 1'b0;
        rs_data = '0;
        rt_hit  = 1'b0;
        rt_data = '0;
        if (write_q && (rd_addr_q == bus.q_rs_addr)) begin
            rs_hit  = 1'b1;
            rs_data = data_in_q;
        end
        if (write_q && (rd_addr_q == bus.q_rt_addr)) begin
            rt_hit  = 1'b1;
            rt_data = data_in_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (ent_rd_q[slot_idx[i]] == bus.q_rs_addr)) begin
                rs_hit  = 1'b1;
                rs_data = ent_data_q[slot_idx[i]];
            end
            if (slot_valid[i] && (ent_rd_q[slot_idx[i]] == bus.q_rt_addr)) begin
                rt_hit  = 1'b1;
                rt_data = ent_data_q[slot_idx[i]];
            end
        end
    end

    assign bus.alu_ready   = alu_ready_w;
    assign bus.mem_ready   = mem_ready_w;
    assign bus.write       = write_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.data_in     = data_in_q;
    assign bus.fwd_rs_hit  = rs_hit;
    assign bus.fwd_rs_data = rs_data;
    assign bus.fwd_rt_hit  = rt_hit;
    assign bus.fwd_rt_data = rt_data;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback
// Directed stimulus with hand-computed expectations for regfile_writeback.
// A monitor logs every write pulse (one line each) into a queue that the
// directed sections compare against their expected write sequences.
// ----------------------------------------------------------------------------
module tb_regfile_writeback;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic clock;
    logic reset;

    regfile_writeback_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int check_cnt = 0;
    int error_cnt = 0;

    logic [ADDR_W+DATA_W-1:0] wq [$];

    always @(negedge clock) begin
        if (!reset && bus.write) begin
            wq.push_back({bus.rd_addr, bus.data_in});
            $display("wb  t=%0t rd=%0d data=0x%0h count=%0d", $time, bus.rd_addr, bus.data_in, bus.count);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
    endtask

    task automatic drive_alu(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic drive_mem(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = rd;
        bus.mem_data  = d;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && bus.count != 0; k++) tick();
        tick();
        check(tag, bus.count, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.q_rs_addr = '0;
        bus.q_rt_addr = '0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        check("rst_write", bus.write, 0);
        check("rst_rdaddr", bus.rd_addr, 0);
        check("rst_datain", bus.data_in, 0);
        check("rst_count", bus.count, 0);
        check("rst_rshit", bus.fwd_rs_hit, 0);
        check("rst_rthit", bus.fwd_rt_hit, 0);
        reset = 1'b0;
        tick();

        // 1: single ALU write, two edges of latency, one-cycle pulse
        wq.delete();
        drive_alu(6'd3, 32'd20);
        #1 check("t1_alurdy", bus.alu_ready, 1);
        tick();
        idle();
        check("t1_cnt1", bus.count, 1);
        check("t1_nowr", bus.write, 0);
        tick();
        check("t1_wr", bus.write, 1);
        check("t1_rd", bus.rd_addr, 3);
        check("t1_data", bus.data_in, 20);
        check("t1_cnt0", bus.count, 0);
        tick();
        check("t1_wrend", bus.write, 0);
        check("t1_hold", bus.data_in, 20);
        check("t1_nwr", wq.size(), 1);

        // 2: ALU and load to the same register in one cycle
        wq.delete();
        bus.q_rs_addr = 6'd5;
        drive_alu(6'd5, 32'd7);
        drive_mem(6'd5, 32'd9);
        #1 check("t2_memrdy", bus.mem_ready, 1);
        check("t2_prehit", bus.fwd_rs_hit, 0);
        tick();
        idle();
        check("t2_cnt2", bus.count, 2);
        check("t2_fwd_q", bus.fwd_rs_data, 9);
        tick();
        check("t2_wr1", {bus.write, bus.rd_addr, bus.data_in}, {1'b1, 6'd5, 32'd7});
        check("t2_hit", bus.fwd_rs_hit, 1);
        check("t2_fwd", bus.fwd_rs_data, 9);
        tick();
        check("t2_wr2", {bus.write, bus.rd_addr, bus.data_in}, {1'b1, 6'd5, 32'd9});
        check("t2_fwd_out", bus.fwd_rs_data, 9);
        tick();
        check("t2_end_hit", bus.fwd_rs_hit, 0);
        check("t2_end_data", bus.fwd_rs_data, 0);
        check("t2_nwr", wq.size(), 2);
        bus.q_rs_addr = '0;

        // 3: six back-to-back loads, ALU idle
        wq.delete();
        for (int k = 0; k < 6; k++) begin
            drive_mem(6'(10 + k), 32'(100 + k));
            #1 check("t3_mrdy", bus.mem_ready, 1);
            tick();
            check("t3_cnt", bus.count, 1);
        end
        idle();
        drain("t3_drain");
        check("t3_nwr", wq.size(), 6);
        for (int k = 0; k < 6 && k < wq.size(); k++)
            check("t3_wb", wq[k], {6'(10 + k), 32'(100 + k)});

        // 4: count=3 with both sources valid accepts only the ALU entry
        wq.delete();
        drive_alu(6'd1, 32'h11);
        drive_mem(6'd2, 32'h12);
        tick();
        drive_alu(6'd3, 32'h13);
        drive_mem(6'd4, 32'h14);
        #1 check("t4_mrdy2", bus.mem_ready, 1);
        tick();
        check("t4_cnt3", bus.count, 3);
        drive_alu(6'd5, 32'h15);
        drive_mem(6'd6, 32'h16);
        #1 check("t4_alurdy", bus.alu_ready, 1);
        check("t4_memrdy0", bus.mem_ready, 0);
        tick();
        check("t4_cnt3b", bus.count, 3);
        bus.alu_valid = 1'b0;
        #1 check("t4_memrdy1", bus.mem_ready, 1);
        tick();
        idle();
        drain("t4_drain");
        check("t4_nwr", wq.size(), 6);
        for (int k = 0; k < 6 && k < wq.size(); k++)
            check("t4_wb", wq[k], {6'(1 + k), 32'(32'h11 + k)});

        // 5: forwarding on rt, youngest of two same-register writes wins
        wq.delete();
        bus.q_rt_addr = 6'd9;
        #1 check("t5_miss_hit", bus.fwd_rt_hit, 0);
        check("t5_miss_data", bus.fwd_rt_data, 0);
        drive_alu(6'd9, 32'hA);
        tick();
        drive_alu(6'd9, 32'hB);
        #1 check("t5_a", {bus.fwd_rt_hit, bus.fwd_rt_data}, {1'b1, 32'hA});
        tick();
        idle();
        check("t5_b_q", {bus.fwd_rt_hit, bus.fwd_rt_data}, {1'b1, 32'hB});
        check("t5_wr_a", bus.data_in, 32'hA);
        tick();
        check("t5_b_out", {bus.fwd_rt_hit, bus.fwd_rt_data}, {1'b1, 32'hB});
        check("t5_wr_b", {bus.write, bus.data_in}, {1'b1, 32'hB});
        tick();
        check("t5_end", {bus.fwd_rt_hit, bus.fwd_rt_data}, {1'b0, 32'h0});
        bus.q_rt_addr = '0;

        // 6: asynchronous reset with three entries queued and write high
        drive_alu(6'd20, 32'h20);
        drive_mem(6'd21, 32'h21);
        tick();
        drive_alu(6'd22, 32'h22);
        drive_mem(6'd23, 32'h23);
        tick();
        idle();
        bus.q_rs_addr = 6'd23;
        #1 check("t6_pre_cnt", bus.count, 3);
        check("t6_pre_wr", bus.write, 1);
        check("t6_pre_hit", bus.fwd_rs_hit, 1);
        #1 reset = 1'b1;
        wq.delete();
        #1 check("t6_wr0", bus.write, 0);
        check("t6_cnt0", bus.count, 0);
        check("t6_hit0", bus.fwd_rs_hit, 0);
        check("t6_rd0", bus.rd_addr, 0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t6_nowr", wq.size(), 0);
        check("t6_cnt_end", bus.count, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end
endmodule
